// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: FSM state codes, opcodes, ALU operand/op selects
// and the bundled control word driven by the controller.
package cpu_pkg;

    typedef enum logic [3:0] {
        RST_IDLE = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        LD_WB    = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_source;
        logic       alu_src_a;
        logic       reg_write;
        logic       mem_to_reg;
        logic       trap;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // An instruction retires on the edge leaving its final state.
    function automatic logic is_retire(input state_t s, input logic mem_ready);
        return (s == LD_WB) || (s == R_WB) || (s == BRANCH) || ((s == MEM_WR) && mem_ready);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state-to-control decode for the multicycle controller.
module mc_out_decode
    import cpu_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            // Branch target is precomputed here so BRANCH can compare and redirect in one cycle.
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            LD_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = 1'b1;
                ctrl.pc_write  = zero;
            end
            TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: state register, next-state logic and retired-instruction counter;
// control outputs come from mc_out_decode.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSource,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        Trap,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [3:0]  state,
    output logic [31:0] InstrRetired
);

    state_t      state_q;
    state_t      state_d;
    logic        retire;
    logic [31:0] instr_retired;
    ctrl_t       ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RST_IDLE;
            instr_retired <= '0;
        end else begin
            state_q       <= state_d;
            instr_retired <= instr_retired + {31'd0, retire};
        end
    end

    assign retire = is_retire(state_q, mem_ready);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RST_IDLE: state_d = FETCH;
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (opcode == OP_R)                            state_d = EXEC_R;
                else if ((opcode == OP_LD) || (opcode == OP_SD)) state_d = MEM_ADDR;
                else if (opcode == OP_BEQ)                     state_d = BRANCH;
                else                                           state_d = TRAP;
            end
            MEM_ADDR: state_d = (opcode == OP_LD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_d = LD_WB;
            LD_WB:    state_d = FETCH;
            MEM_WR:   if (mem_ready) state_d = FETCH;
            EXEC_R:   state_d = R_WB;
            R_WB:     state_d = FETCH;
            BRANCH:   state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = RST_IDLE;
        endcase
    end

    mc_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .zero      (Zero),
        .ctrl      (ctrl)
    );

    assign MemRead      = ctrl.mem_read;
    assign MemWrite     = ctrl.mem_write;
    assign IorD         = ctrl.iord;
    assign IRWrite      = ctrl.ir_write;
    assign PCWrite      = ctrl.pc_write;
    assign PCSource     = ctrl.pc_source;
    assign ALUSrcA      = ctrl.alu_src_a;
    assign RegWrite     = ctrl.reg_write;
    assign MemtoReg     = ctrl.mem_to_reg;
    assign Trap         = ctrl.trap;
    assign ALUSrcB      = ctrl.alu_src_b;
    assign ALUOp        = ctrl.alu_op;
    assign state        = state_q;
    assign InstrRetired = instr_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource;
    logic        ALUSrcA, RegWrite, MemtoReg, Trap;
    logic [1:0]  ALUSrcB, ALUOp;
    logic [3:0]  state;
    logic [31:0] InstrRetired;

    logic [13:0] ctrl_vec;
    logic [31:0] cnt_m = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam int K_R = 0, K_LD = 1, K_SD = 2, K_BEQ = 3;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .Trap(Trap), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .state(state), .InstrRetired(InstrRetired)
    );

    always #5 clk = ~clk;

    assign ctrl_vec = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
                       RegWrite, MemtoReg, Trap, ALUSrcB, ALUOp};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control word each state should present, written straight from the state descriptions.
    function automatic logic [13:0] exp_ctrl(input state_t s, input logic mr, input logic z);
        logic mrd, mwr, iord, irw, pcw, pcs, sa, rw, m2r, tr;
        logic [1:0] sb, aop;
        {mrd, mwr, iord, irw, pcw, pcs, sa, rw, m2r, tr} = '0;
        sb = 2'b00; aop = 2'b00;
        case (s)
            FETCH:    begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            DECODE:   begin sb = 2'b10; end
            MEM_ADDR: begin sa = 1; sb = 2'b10; end
            MEM_RD:   begin mrd = 1; iord = 1; end
            LD_WB:    begin rw = 1; m2r = 1; end
            MEM_WR:   begin mwr = 1; iord = 1; end
            EXEC_R:   begin sa = 1; aop = 2'b10; end
            R_WB:     begin rw = 1; end
            BRANCH:   begin sa = 1; aop = 2'b01; pcs = 1; pcw = z; end
            TRAP:     begin tr = 1; end
            default:  ;
        endcase
        return {mrd, mwr, iord, irw, pcw, pcs, sa, rw, m2r, tr, sb, aop};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic [6:0] op_of(input int kind);
        case (kind)
            K_R:     return 7'b0110011;
            K_LD:    return 7'b0000011;
            K_SD:    return 7'b0100011;
            default: return 7'b1100011;
        endcase
    endfunction

    // Illegal opcode: often a single-bit neighbour of a legal one to probe exact matching.
    function automatic logic [6:0] bad_op();
        logic [6:0] v;
        do begin
            if ($urandom_range(0, 1) == 1)
                v = op_of($urandom_range(0, 3)) ^ (7'd1 << $urandom_range(0, 6));
            else
                v = 7'($urandom);
        end while (v == 7'b0110011 || v == 7'b0000011 || v == 7'b0100011 || v == 7'b1100011);
        return v;
    endfunction

    task automatic step(input state_t es, input logic mr, input logic z, input logic [6:0] op);
        @(posedge clk);
        #1;
        mem_ready = mr;
        Zero      = z;
        opcode    = op;
        @(negedge clk);
        chk("state", {28'd0, state}, {28'd0, es});
        chk("ctrl", {18'd0, ctrl_vec}, {18'd0, exp_ctrl(es, mr, z)});
        chk("count", InstrRetired, cnt_m);
        chk("rd_wr_excl", {31'd0, MemRead & MemWrite}, 32'd0);
        if (es == LD_WB || es == R_WB || es == BRANCH || (es == MEM_WR && mr))
            cnt_m = cnt_m + 32'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", {28'd0, state}, {28'd0, RST_IDLE});
        chk("rst_ctrl", {18'd0, ctrl_vec}, 32'd0);
        chk("rst_count", InstrRetired, 32'd0);
        cnt_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = rbit();
        opcode    = rop();
        #1;
        chk("idle_state", {28'd0, state}, {28'd0, RST_IDLE});
    endtask

    task automatic run_instr(input int kind, input int fw, input int mw, input logic z);
        logic [6:0] op;
        op = op_of(kind);
        for (int i = 0; i < fw; i++) step(FETCH, 1'b0, rbit(), rop());
        step(FETCH, 1'b1, rbit(), rop());
        step(DECODE, rbit(), rbit(), op);
        case (kind)
            K_R: begin
                step(EXEC_R, rbit(), rbit(), rop());
                step(R_WB, rbit(), rbit(), rop());
            end
            K_LD: begin
                step(MEM_ADDR, rbit(), rbit(), op);
                for (int i = 0; i < mw; i++) step(MEM_RD, 1'b0, rbit(), rop());
                step(MEM_RD, 1'b1, rbit(), rop());
                step(LD_WB, rbit(), rbit(), rop());
            end
            K_SD: begin
                step(MEM_ADDR, rbit(), rbit(), op);
                for (int i = 0; i < mw; i++) step(MEM_WR, 1'b0, rbit(), rop());
                step(MEM_WR, 1'b1, rbit(), rop());
            end
            default: step(BRANCH, rbit(), z, rop());
        endcase
    endtask

    initial begin
        do_reset();

        // Directed: R-type, stalled load, taken then untaken branch.
        run_instr(K_R, 0, 0, 1'b0);
        run_instr(K_LD, 0, 3, 1'b0);
        run_instr(K_BEQ, 0, 0, 1'b1);
        run_instr(K_BEQ, 0, 0, 1'b0);
        step(FETCH, 1'b0, 1'b0, rop());
        chk("count_after_directed", InstrRetired, 32'd4);

        // Random instruction stream with random memory stalls.
        for (int n = 0; n < 200; n++) begin
            run_instr($urandom_range(0, 3),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      rbit());
        end

        // Illegal opcode traps and holds until reset.
        for (int t = 0; t < 3; t++) begin
            do_reset();
            run_instr(K_R, 0, 0, 1'b0);
            step(FETCH, 1'b1, rbit(), rop());
            step(DECODE, rbit(), rbit(), bad_op());
            for (int i = 0; i < 20; i++) step(TRAP, rbit(), rbit(), rop());
            chk("trap_count", InstrRetired, 32'd1);
        end
        do_reset();

        // Counter wrap: preload all-ones, then complete a store.
        force dut.instr_retired = 32'hFFFF_FFFF;
        cnt_m = 32'hFFFF_FFFF;
        step(FETCH, 1'b0, rbit(), rop());
        release dut.instr_retired;
        run_instr(K_SD, 0, 0, 1'b0);
        step(FETCH, 1'b0, rbit(), rop());
        chk("wrap_count", InstrRetired, 32'd0);

        // Reset asserted while a store waits on memory.
        step(FETCH, 1'b1, rbit(), rop());
        step(DECODE, rbit(), rbit(), op_of(K_SD));
        step(MEM_ADDR, rbit(), rbit(), op_of(K_SD));
        step(MEM_WR, 1'b0, rbit(), rop());
        @(posedge clk);
        #1;
        chk("memwr_held", {31'd0, MemWrite}, 32'd1);
        do_reset();
        run_instr(K_LD, 1, 1, 1'b0);
        step(FETCH, 1'b1, rbit(), rop());
        chk("count_after_abort", InstrRetired, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "simulation time limit reached");
    end

endmodule
